l2min2_mc: RTL and testbench

Parametrised multi-channel L2min2 reconstruction filter for incremental delta-sigma converters. It converts N_CH parallel 1-bit bitstreams into N_CH weighted-sum conversion results over a frame of 2M-1 samples, with M programmable per conversion. It sits directly behind the modulator array and replaces the single-channel, free-running reconstruction filter. It adds start/valid/ready handshakes, sample-enable stalling and fully synchronous single-clock operation.

---
 rtl/l2min2_pkg.sv | 22 ++
 rtl/l2min2_wgen.sv | 70 +++++++
 rtl/l2min2_mc.sv | 116 +++++++++++
 tb/tb_l2min2_mc.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l2min2_pkg.sv
// rtl/l2min2_pkg.sv - shared types, width helpers and weight-mode constants for l2min2_mc
package l2min2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic MODE_L2MIN2 = 1'b0;
   localparam logic MODE_COI2   = 1'b1;

   // Peak weight M(M+1)/2 and the frame sum both stay below these widths for M < 2^M_W.
   function automatic int l2min2_w_w(input int m_w);
      return 2 * m_w;
   endfunction

   function automatic int l2min2_out_w(input int m_w);
      return 3 * m_w;
   endfunction

endpackage

// File: rtl/l2min2_wgen.sv
// rtl/l2min2_wgen.sv - shared L2min2/CoI2 weight generator built from a step/weight recurrence
module l2min2_wgen
   import l2min2_pkg::*;
#(
   parameter int M_W = 10,
   parameter int W_W = l2min2_w_w(M_W)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [M_W-1:0] m,
   input  logic           mode,
   input  logic           advance,
   output logic [W_W-1:0] w,
   output logic           last
);

   logic [W_W-1:0] w_q;
   logic [M_W-1:0] step_q;
   logic           falling_q;
   logic           mode_q;
   logic [M_W:0]   k_q;
   logic [M_W:0]   last_k_q;
   logic [M_W:0]   two_m;

   assign two_m = {m, 1'b0};

   always_ff @(posedge clk) begin
      if (rst) begin
         w_q       <= '0;
         step_q    <= '0;
         falling_q <= 1'b0;
         mode_q    <= MODE_L2MIN2;
         k_q       <= '0;
         last_k_q  <= '0;
      end else if (load) begin
         if (mode == MODE_COI2)
            w_q <= {{(W_W-M_W-1){1'b0}}, two_m - (M_W+1)'(1)};
         else
            w_q <= {{(W_W-M_W){1'b0}}, m};
         step_q    <= m - M_W'(1);
         falling_q <= 1'b0;
         mode_q    <= mode;
         k_q       <= '0;
         last_k_q  <= two_m - (M_W+1)'(2);
      end else if (advance) begin
         k_q <= k_q + (M_W+1)'(1);
         if (mode_q == MODE_COI2) begin
            w_q <= w_q - W_W'(1);
         end else if (!falling_q) begin
            // step reaches zero exactly at the peak k=M-1; the descent then mirrors the ascent
            if (step_q == '0) begin
               falling_q <= 1'b1;
               w_q       <= w_q - W_W'(1);
               step_q    <= M_W'(2);
            end else begin
               w_q    <= w_q + {{(W_W-M_W){1'b0}}, step_q};
               step_q <= step_q - M_W'(1);
            end
         end else begin
            w_q    <= w_q - {{(W_W-M_W){1'b0}}, step_q};
            step_q <= step_q + M_W'(1);
         end
      end
   end

   assign w    = w_q;
   assign last = (k_q == last_k_q);

endmodule

// File: rtl/l2min2_mc.sv
// rtl/l2min2_mc.sv - multi-channel L2min2 reconstruction filter; L2MIN2_COI_EN adds mode_in for CoI2 weights
module l2min2_mc
   import l2min2_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int M_W   = 10,
   parameter int W_W   = l2min2_w_w(M_W),
   parameter int OUT_W = l2min2_out_w(M_W)
) (
   input  logic                  clk,
   input  logic                  rst_in,
   input  logic                  start_in,
`ifdef L2MIN2_COI_EN
   input  logic                  mode_in,
`endif
   input  logic [M_W-1:0]        M_in,
   input  logic                  d_valid_in,
   input  logic [N_CH-1:0]       d_in,
   output logic [N_CH*OUT_W-1:0] d_out,
   output logic                  d_out_valid,
   input  logic                  d_out_ready,
   output logic                  busy,
   output logic                  err
);

   state_t         state_q;
   state_t         state_d;
   logic           load;
   logic           advance;
   logic           err_d;
   logic           err_q;
   logic           mode_sel;
   logic [W_W-1:0] w;
   logic           last;
   logic [OUT_W-1:0] acc [N_CH];

`ifdef L2MIN2_COI_EN
   assign mode_sel = mode_in;
`else
   assign mode_sel = MODE_L2MIN2;
`endif

   l2min2_wgen #(
      .M_W (M_W),
      .W_W (W_W)
   ) u_wgen (
      .clk     (clk),
      .rst     (rst_in),
      .load    (load),
      .m       (M_in),
      .mode    (mode_sel),
      .advance (advance),
      .w       (w),
      .last    (last)
   );

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      advance = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_in) begin
               if (M_in != '0) begin
                  load    = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (d_valid_in) begin
               advance = 1'b1;
               if (last)
                  state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (d_out_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Accumulators double as the output register: they only move in RUN and are cleared on start.
   always_ff @(posedge clk) begin
      for (int c = 0; c < N_CH; c++) begin
         if (rst_in || load)
            acc[c] <= '0;
         else if (advance && d_in[c])
            acc[c] <= acc[c] + {{(OUT_W-W_W){1'b0}}, w};
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_out
      assign d_out[c*OUT_W +: OUT_W] = acc[c];
   end

   assign d_out_valid = (state_q == ST_HOLD);
   assign busy        = (state_q != ST_IDLE);
   assign err         = err_q;

endmodule

// File: tb/tb_l2min2_mc.sv
// tb/tb_l2min2_mc.sv - directed self-checking bench for l2min2_mc
module tb_l2min2_mc;

   localparam int N_CH  = 4;
   localparam int M_W   = 10;
   localparam int OUT_W = 3 * M_W;

   logic                  clk = 1'b0;
   logic                  rst_in = 1'b1;
   logic                  start_in = 1'b0;
   logic                  mode_in = 1'b0;
   logic [M_W-1:0]        M_in = '0;
   logic                  d_valid_in = 1'b0;
   logic [N_CH-1:0]       d_in = '0;
   logic [N_CH*OUT_W-1:0] d_out;
   logic                  d_out_valid;
   logic                  d_out_ready = 1'b0;
   logic                  busy;
   logic                  err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   l2min2_mc #(
      .N_CH (N_CH),
      .M_W  (M_W)
   ) dut (
      .clk         (clk),
      .rst_in      (rst_in),
      .start_in    (start_in),
`ifdef L2MIN2_COI_EN
      .mode_in     (mode_in),
`endif
      .M_in        (M_in),
      .d_valid_in  (d_valid_in),
      .d_in        (d_in),
      .d_out       (d_out),
      .d_out_valid (d_out_valid),
      .d_out_ready (d_out_ready),
      .busy        (busy),
      .err         (err)
   );

   function automatic logic [N_CH*OUT_W-1:0] pack4(input longint e0, input longint e1,
                                                   input longint e2, input longint e3);
      logic [N_CH*OUT_W-1:0] v;
      v = '0;
      v[0*OUT_W +: OUT_W] = OUT_W'(e0);
      v[1*OUT_W +: OUT_W] = OUT_W'(e1);
      v[2*OUT_W +: OUT_W] = OUT_W'(e2);
      v[3*OUT_W +: OUT_W] = OUT_W'(e3);
      return v;
   endfunction

   // Frame sum straight from the weight definition, not from a recurrence.
   function automatic longint l2_sum(input longint m);
      longint total, wk;
      total = 0;
      for (longint k = 0; k < m; k++) begin
         wk = 0;
         for (longint j = 0; j <= k; j++) wk += m - j;
         total += (k == m - 1) ? wk : 2 * wk;
      end
      return total;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [M_W-1:0] m);
      start_in = 1'b1;
      M_in     = m;
      tick();
      start_in = 1'b0;
   endtask

   task automatic feed(input logic [N_CH-1:0] bits);
      d_valid_in = 1'b1;
      d_in       = bits;
      tick();
      d_valid_in = 1'b0;
      d_in       = '0;
   endtask

   task automatic release_result();
      d_out_ready = 1'b1;
      tick();
      d_out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      tick();
      tick();
      rst_in = 1'b0;
      n_vec++; if (d_out !== '0) begin n_err++; $display("FAIL reset_d_out got %h want 0", d_out); end
      n_vec++; if (d_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", d_out_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err); end
   endtask

   task automatic test_m2_all_ones();
      do_start(10'd2);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL m2_busy got %b want 1", busy); end
      feed(4'b1111);
      feed(4'b1111);
      n_vec++; if (d_out_valid !== 1'b0) begin n_err++; $display("FAIL m2_early_valid got %b want 0", d_out_valid); end
      feed(4'b1111);
      n_vec++; if (d_out_valid !== 1'b1) begin n_err++; $display("FAIL m2_valid got %b want 1", d_out_valid); end
      n_vec++; if (d_out !== pack4(7, 7, 7, 7)) begin n_err++; $display("FAIL m2_result got %h want %h", d_out, pack4(7, 7, 7, 7)); end
      release_result();
      n_vec++; if (d_out_valid !== 1'b0) begin n_err++; $display("FAIL m2_valid_drop got %b want 0", d_out_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL m2_idle_busy got %b want 0", busy); end
      n_vec++; if (d_out !== pack4(7, 7, 7, 7)) begin n_err++; $display("FAIL m2_idle_keep got %h want %h", d_out, pack4(7, 7, 7, 7)); end
   endtask

   task automatic test_m3_patterns();
      do_start(10'd3);
      for (int k = 0; k < 5; k++) feed({1'b0, (k == 2), 1'b0, 1'b1});
      n_vec++; if (d_out_valid !== 1'b1) begin n_err++; $display("FAIL m3_valid got %b want 1", d_out_valid); end
      n_vec++; if (d_out !== pack4(22, 0, 6, 0)) begin n_err++; $display("FAIL m3_result got %h want %h", d_out, pack4(22, 0, 6, 0)); end
      release_result();
   endtask

   task automatic test_valid_toggle();
      do_start(10'd3);
      d_in = 4'b1111;
      for (int i = 0; i < 9; i++) begin
         d_valid_in = (i % 2 == 0);
         tick();
         if (i == 7) begin
            n_vec++; if (d_out_valid !== 1'b0) begin n_err++; $display("FAIL toggle_early_valid got %b want 0", d_out_valid); end
         end
      end
      d_valid_in = 1'b0;
      d_in = '0;
      n_vec++; if (d_out_valid !== 1'b1) begin n_err++; $display("FAIL toggle_valid got %b want 1", d_out_valid); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++; if (d_out_valid !== 1'b1) begin n_err++; $display("FAIL toggle_hold_valid cycle %0d got %b want 1", i, d_out_valid); end
         n_vec++; if (d_out !== pack4(22, 22, 22, 22)) begin n_err++; $display("FAIL toggle_hold_data cycle %0d got %h want %h", i, d_out, pack4(22, 22, 22, 22)); end
      end
      release_result();
      n_vec++; if (d_out_valid !== 1'b0) begin n_err++; $display("FAIL toggle_release got %b want 0", d_out_valid); end
   endtask

   task automatic test_err();
      do_start(10'd0);
      n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_pulse got %b want 1", err); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL err_busy got %b want 0", busy); end
      tick();
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_once got %b want 0", err); end
   endtask

   task automatic test_start_ignored();
      do_start(10'd2);
      feed(4'b1111);
      start_in = 1'b1;
      M_in     = 10'd3;
      feed(4'b1111);
      start_in = 1'b0;
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL ign_err got %b want 0", err); end
      feed(4'b1111);
      n_vec++; if (d_out !== pack4(7, 7, 7, 7)) begin n_err++; $display("FAIL ign_run_result got %h want %h", d_out, pack4(7, 7, 7, 7)); end
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      n_vec++; if (d_out_valid !== 1'b1) begin n_err++; $display("FAIL ign_hold_valid got %b want 1", d_out_valid); end
      n_vec++; if (d_out !== pack4(7, 7, 7, 7)) begin n_err++; $display("FAIL ign_hold_result got %h want %h", d_out, pack4(7, 7, 7, 7)); end
      release_result();
   endtask

   task automatic test_reset_mid_run();
      do_start(10'd3);
      feed(4'b1111);
      feed(4'b1111);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
      n_vec++; if (d_out !== '0) begin n_err++; $display("FAIL rst_d_out got %h want 0", d_out); end
      do_start(10'd2);
      for (int k = 0; k < 3; k++) feed(4'b1111);
      n_vec++; if (d_out !== pack4(7, 7, 7, 7)) begin n_err++; $display("FAIL rst_rerun got %h want %h", d_out, pack4(7, 7, 7, 7)); end
      release_result();
   endtask

   task automatic test_back_to_back();
      do_start(10'd1);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", busy); end
      feed(4'b0101);
      n_vec++; if (d_out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %b want 1", d_out_valid); end
      n_vec++; if (d_out !== pack4(1, 0, 1, 0)) begin n_err++; $display("FAIL b2b_m1 got %h want %h", d_out, pack4(1, 0, 1, 0)); end
      release_result();
      do_start(10'd1);
      feed(4'b1010);
      n_vec++; if (d_out !== pack4(0, 1, 0, 1)) begin n_err++; $display("FAIL b2b_second got %h want %h", d_out, pack4(0, 1, 0, 1)); end
      release_result();
   endtask

   task automatic test_max_m();
      longint s;
      s = l2_sum(1023);
      do_start(10'd1023);
      for (int k = 0; k < 2045; k++) feed(4'b1111);
      n_vec++; if (d_out_valid !== 1'b1) begin n_err++; $display("FAIL maxm_valid got %b want 1", d_out_valid); end
      n_vec++; if (d_out !== pack4(s, s, s, s)) begin n_err++; $display("FAIL maxm_result got %h want %h", d_out, pack4(s, s, s, s)); end
      release_result();
   endtask

`ifdef L2MIN2_COI_EN
   task automatic test_coi();
      mode_in = 1'b1;
      do_start(10'd2);
      mode_in = 1'b0;
      for (int k = 0; k < 3; k++) feed(4'b1111);
      n_vec++; if (d_out !== pack4(6, 6, 6, 6)) begin n_err++; $display("FAIL coi_result got %h want %h", d_out, pack4(6, 6, 6, 6)); end
      release_result();
   endtask
`endif

   initial begin
      test_reset();
      test_m2_all_ones();
      test_m3_patterns();
      test_valid_toggle();
      test_err();
      test_start_ignored();
      test_reset_mid_run();
      test_back_to_back();
      test_max_m();
`ifdef L2MIN2_COI_EN
      test_coi();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
